// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the CPU controller (C)
// and a loader/DMA engine (D). Round-robin arbitration; every access runs
// through ISSUE, an optional read WAIT phase, and DONE, presenting exactly
// one memory command. All outputs come from registers, so request-side
// timing never reaches the memory pins combinationally.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  // The wait counter is only 3 bits wide, so larger latencies cannot be counted.
  if ((RD_LAT < 1) || (RD_LAT > 7)) begin : g_rd_lat_check
    $error("mem_port_arbiter: RD_LAT must be in the range 1..7");
  end

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic              last;
  logic [2:0]        cnt;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              pick_d;

  // D wins when it is the only requester, or on a tie when C was served last.
  assign pick_d = d_req && (!c_req || !last);

  // The command latch drives the memory pins directly and holds through WAIT.
  assign mem_we    = cmd_we;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;

  // Sequencer: arbitration, command latch, wait counting, read capture and pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= 3'd0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      c_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      c_done    <= 1'b0;
      d_done    <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      c_gnt  <= 1'b0;
      d_gnt  <= 1'b0;
      c_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (c_req || d_req) begin
            owner     <= pick_d;
            last      <= pick_d;
            cmd_we    <= pick_d ? d_we    : c_we;
            cmd_addr  <= pick_d ? d_addr  : c_addr;
            cmd_wdata <= pick_d ? d_wdata : c_wdata;
            mem_en    <= 1'b1;
            c_gnt     <= !pick_d;
            d_gnt     <= pick_d;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_we) begin
            c_done <= !owner;
            d_done <= owner;
            state  <= DONE;
          end else begin
            cnt   <= 3'd1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == RD_LAT_C) begin
            rdata  <= mem_rdata;
            c_done <= !owner;
            d_done <= owner;
            state  <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the memory port arbiter. dut_a
// runs with a read latency of 2 and carries the scoreboard; dut_b shares
// every input but has a read latency of 3, for the reset-during-wait case.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;

  logic        a_c_gnt, a_c_done, a_d_gnt, a_d_done, a_mem_en, a_mem_we, a_busy, a_owner;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_c_gnt, b_c_done, b_d_gnt, b_d_done, b_mem_en, b_mem_we, b_busy, b_owner;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  typedef struct {
    logic        owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic        gnt_log[$];
  exp_t        mon_e;
  logic [31:0] last_rd = 32'd0;
  logic        prev_en = 1'b0;
  logic        b_first_seen = 1'b0;
  logic        b_first_owner = 1'b0;
  int          errors = 0;
  int          checks = 0;

  logic [32:0] pipe_a0, pipe_a1;
  logic [32:0] pipe_b0, pipe_b1, pipe_b2;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) dut_a (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(a_c_gnt), .c_done(a_c_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(a_d_gnt), .d_done(a_d_done),
    .rdata(a_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(b_c_gnt), .c_done(b_c_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(b_d_gnt), .d_done(b_d_done),
    .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
  );

  function automatic logic [31:0] rd_fn(input logic [31:0] addr);
    return (addr == 32'h40) ? 32'hDEADBEEF : (addr ^ 32'h5A5A_0000);
  endfunction

  // Memory models: read data is valid only in the cycle RD_LAT after the issue cycle.
  always @(posedge clk) begin
    pipe_a0 <= (a_mem_en && !a_mem_we) ? {1'b1, rd_fn(a_mem_addr)} : 33'd0;
    pipe_a1 <= pipe_a0;
    pipe_b0 <= (b_mem_en && !b_mem_we) ? {1'b1, rd_fn(b_mem_addr)} : 33'd0;
    pipe_b1 <= pipe_b0;
    pipe_b2 <= pipe_b1;
  end
  assign a_mem_rdata = pipe_a1[32] ? pipe_a1[31:0] : 32'hBAD0_BAD0;
  assign b_mem_rdata = pipe_b2[32] ? pipe_b2[31:0] : 32'hBAD0_BAD0;

  // Scoreboard monitor for dut_a plus protocol invariants.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_en = 1'b0;
      end else begin
        if (a_mem_en) begin
          checks++;
          if (prev_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mem_en_gap: mem_en=1 in two consecutive cycles, required 0 before issue");
          end
        end
        if (a_c_gnt || a_d_gnt || a_c_done || a_d_done) begin
          checks++;
          if ((a_c_gnt && a_d_gnt) || (a_c_done && a_d_done)) begin
            errors++;
            $display("[TB] FAIL pulse_overlap: gnt=%b%b done=%b%b, required at most one requester", a_c_gnt, a_d_gnt, a_c_done, a_d_done);
          end
        end
        if (a_c_gnt || a_d_gnt) begin
          gnt_log.push_back(a_d_gnt);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_gnt: gnt for owner %b with nothing expected", a_d_gnt);
          end else begin
            mon_e = exp_q[0];
            checks++;
            if ({a_d_gnt, a_mem_en, a_mem_we, a_mem_addr} !== {mon_e.owner, 1'b1, mon_e.we, mon_e.addr}) begin
              errors++;
              $display("[TB] FAIL issue_cmd: owner=%b en=%b we=%b addr=%h, required owner=%b en=1 we=%b addr=%h",
                       a_d_gnt, a_mem_en, a_mem_we, a_mem_addr, mon_e.owner, mon_e.we, mon_e.addr);
            end
            if (mon_e.we) begin
              checks++;
              if (a_mem_wdata !== mon_e.wdata) begin
                errors++;
                $display("[TB] FAIL issue_wdata: got %h, required %h", a_mem_wdata, mon_e.wdata);
              end
            end
          end
        end
        if (a_c_done || a_d_done) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_done: done for owner %b with nothing expected", a_d_done);
          end else begin
            mon_e = exp_q.pop_front();
            if (!mon_e.we) last_rd = mon_e.rdata;
            checks++;
            if ({a_d_done, a_rdata} !== {mon_e.owner, last_rd}) begin
              errors++;
              $display("[TB] FAIL done_data: owner=%b rdata=%h, required owner=%b rdata=%h",
                       a_d_done, a_rdata, mon_e.owner, last_rd);
            end
          end
        end
        prev_en = a_mem_en;
        if ((b_c_gnt || b_d_gnt) && !b_first_seen) begin
          b_first_seen  = 1'b1;
          b_first_owner = b_d_gnt;
        end
      end
    end
  end

  task automatic set_c(input int i);
    c_we    = i[0];
    c_addr  = 32'h200 + 32'(4 * i);
    c_wdata = 32'hC000_0000 + 32'(i);
  endtask

  task automatic set_d(input int i);
    d_we    = ~i[0];
    d_addr  = 32'h300 + 32'(4 * i);
    d_wdata = 32'hD000_0000 + 32'(i);
  endtask

  task automatic push_exp(input logic own, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.owner = own;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = rd_fn(addr);
    exp_q.push_back(e);
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    last_rd = 32'd0;
    b_first_seen = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (a_busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (a_busy) begin
      errors++;
      $display("[TB] FAIL idle_timeout: busy=%b after 60 cycles, required 0", a_busy);
    end
  endtask

  // Both requesters hold req high; each loads its next access after its grant.
  task automatic run_dual(input int n);
    int ci = 0;
    int di = 0;
    int budget = 0;
    for (int k = 0; k < n; k++) begin
      set_c(k); push_exp(1'b0, c_we, c_addr, c_wdata);
      set_d(k); push_exp(1'b1, d_we, d_addr, d_wdata);
    end
    @(posedge clk); #1;
    set_c(0); set_d(0);
    c_req = 1'b1; d_req = 1'b1;
    while ((ci < n || di < n) && budget < 40 * n) begin
      @(negedge clk);
      budget++;
      if (a_c_gnt) begin
        ci++;
        if (ci < n) set_c(ci); else c_req = 1'b0;
      end
      if (a_d_gnt) begin
        di++;
        if (di < n) set_d(di); else d_req = 1'b0;
      end
    end
    c_req = 1'b0; d_req = 1'b0;
    checks++;
    if (ci < n || di < n) begin
      errors++;
      $display("[TB] FAIL dual_timeout: grants c=%0d d=%0d, required %0d each", ci, di, n);
    end
    wait_idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL dual_leftover: %0d accesses incomplete, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_c_gnt, a_c_done, a_d_gnt, a_d_done, a_mem_en, a_mem_we, a_busy, a_owner, a_mem_addr, a_mem_wdata, a_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: en=%b busy=%b addr=%h rdata=%h, required all 0", a_mem_en, a_busy, a_mem_addr, a_rdata);
    end
    @(posedge clk); #1 reset = 1'b1;
    // Start a read, then abandon it while mem_en is high.
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h80; c_wdata = 32'h0;
    push_exp(1'b0, 1'b0, 32'h80, 32'h0);
    @(posedge clk);
    @(negedge clk);
    c_req = 1'b0;
    checks++;
    if (a_mem_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun_issue: mem_en=%b, required 1", a_mem_en);
    end
    reset = 1'b0;
    exp_q.delete();
    last_rd = 32'd0;
    #1;
    checks++;
    if ({a_mem_en, a_busy, a_c_gnt, a_c_done} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midrun_abort: en=%b busy=%b gnt=%b done=%b, required 0000", a_mem_en, a_busy, a_c_gnt, a_c_done);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_busy, a_mem_en, a_c_done, a_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: busy=%b en=%b done=%b rdata=%h, required 0", a_busy, a_mem_en, a_c_done, a_rdata);
    end
    gnt_log.delete();
    run_dual(1);
    checks++;
    if (gnt_log.size() == 0 || gnt_log[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_tie: first grant %s, required C", (gnt_log.size() == 0) ? "none" : (gnt_log[0] ? "D" : "C"));
    end
  endtask

  task automatic test_cpu_read();
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40; c_wdata = 32'h0;
    push_exp(1'b0, 1'b0, 32'h40, 32'h0);
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        c_req = 1'b0;
        checks++;
        if ({a_c_gnt, a_mem_en, a_mem_we, a_mem_addr} !== {3'b110, 32'h40}) begin
          errors++;
          $display("[TB] FAIL read_issue: gnt=%b en=%b we=%b addr=%h, required 1 1 0 00000040", a_c_gnt, a_mem_en, a_mem_we, a_mem_addr);
        end
      end
      checks++;
      if ({a_d_gnt, a_d_done, a_c_done} !== {2'b00, (k == 4)}) begin
        errors++;
        $display("[TB] FAIL read_done_t%0d: d_gnt=%b d_done=%b c_done=%b, required 0 0 %b", k, a_d_gnt, a_d_done, a_c_done, (k == 4));
      end
    end
    checks++;
    if (a_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL read_rdata: got %h, required deadbeef", a_rdata);
    end
    wait_idle();
  endtask

  task automatic test_dma_write();
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h12345678;
    push_exp(1'b1, 1'b1, 32'h100, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    d_req = 1'b0;
    checks++;
    if ({a_d_gnt, a_c_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {4'b1011, 32'h100, 32'h12345678}) begin
      errors++;
      $display("[TB] FAIL write_issue: d_gnt=%b en=%b we=%b addr=%h wdata=%h, required 1 1 1 00000100 12345678",
               a_d_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
    end
    @(negedge clk);
    checks++;
    if ({a_mem_en, a_d_done, a_rdata} !== {2'b01, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL write_done: en=%b d_done=%b rdata=%h, required 0 1 deadbeef", a_mem_en, a_d_done, a_rdata);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    gnt_log.delete();
    run_dual(3);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= gnt_log.size() || gnt_log[k] !== k[0]) begin
        errors++;
        $display("[TB] FAIL grant_order_%0d: got %s, required %s", k,
                 (k >= gnt_log.size()) ? "none" : (gnt_log[k] ? "D" : "C"), k[0] ? "D" : "C");
      end
    end
  endtask

  task automatic test_reset_in_wait();
    apply_reset(2);
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40; c_wdata = 32'h0;
    push_exp(1'b0, 1'b0, 32'h40, 32'h0);
    @(posedge clk);
    @(negedge clk);
    c_req = 1'b0;
    checks++;
    if ({b_c_gnt, b_mem_en} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL lat3_issue: gnt=%b en=%b, required 1 1", b_c_gnt, b_mem_en);
    end
    @(negedge clk);
    checks++;
    if ({b_mem_en, b_busy, b_mem_addr} !== {2'b01, 32'h40}) begin
      errors++;
      $display("[TB] FAIL lat3_wait: en=%b busy=%b addr=%h, required 0 1 00000040", b_mem_en, b_busy, b_mem_addr);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    exp_q.delete();
    last_rd = 32'd0;
    #1;
    checks++;
    if ({b_mem_en, b_busy, b_c_done, b_mem_addr} !== '0) begin
      errors++;
      $display("[TB] FAIL lat3_abort: en=%b busy=%b done=%b addr=%h, required 0", b_mem_en, b_busy, b_c_done, b_mem_addr);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({b_c_done, a_c_done, b_busy} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL lat3_no_done_%0d: b_done=%b a_done=%b b_busy=%b, required 0 0 0", k, b_c_done, a_c_done, b_busy);
      end
    end
    b_first_seen = 1'b0;
    gnt_log.delete();
    run_dual(1);
    checks++;
    if (!b_first_seen || b_first_owner !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lat3_tie: seen=%b first owner=%b, required C (0)", b_first_seen, b_first_owner);
    end
  endtask

  task automatic test_addr_change();
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40; c_wdata = 32'h0;
    push_exp(1'b0, 1'b0, 32'h40, 32'h0);
    @(posedge clk); #1;
    c_addr = 32'h80;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      c_req = 1'b0;
      checks++;
      if ({a_mem_addr, a_c_done} !== {32'h40, (k == 4)}) begin
        errors++;
        $display("[TB] FAIL addr_hold_t%0d: addr=%h done=%b, required 00000040 %b", k, a_mem_addr, a_c_done, (k == 4));
      end
    end
    checks++;
    if (a_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL addr_hold_rdata: got %h, required deadbeef", a_rdata);
    end
    wait_idle();
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_back_to_back();
    test_reset_in_wait();
    test_addr_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
